// File: rtl/regfile_pkg.sv
// Shared sizing defaults and slice helpers for the register file.
// Used by the top level and by every read-port instance.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_NRD   = 2;
   localparam int ZERO_ADDR = 0;

   // Low bit of slice 'port' in a bus built from back-to-back fields of 'w' bits.
   function automatic int slice_lo(input int port, input int w);
      return port * w;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, zero-register masking, write bypass.
// Zero latency, purely combinational, no backpressure.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic [DEPTH*WIDTH-1:0] mem,
   input  logic [DEPTH-1:0]       busy_vec,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   bs_en,
   input  logic [ADDR_W-1:0]      bs_addr,
   output logic [WIDTH-1:0]       data,
   output logic                   flag
);

   logic is_zero;

   assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));

   always_comb begin
      data = mem[int'(addr)*WIDTH +: WIDTH];
      flag = busy_vec[addr];
      if (is_zero) begin
         data = '0;
         flag = 1'b0;
      end else if (wr_en && (wr_addr == addr)) begin
         // A producer re-claiming the register on the same edge keeps it busy.
         data = wr_data;
         flag = bs_en && (bs_addr == addr);
      end
   end

endmodule

// File: rtl/register_file.sv
// Multi-port register file with write bypass and a per-register busy scoreboard.
// Reads are combinational, writes and busy-sets land on the rising edge; no backpressure.
module register_file
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NRD      = DEF_NRD,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NRD*ADDR_W-1:0]   rd_addr,
   output logic [NRD*WIDTH-1:0]    rd_data,
   output logic [NRD-1:0]          rd_busy,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    bs_en,
   input  logic [ADDR_W-1:0]       bs_addr,
   output logic                    busy_any
);

   logic [DEPTH*WIDTH-1:0] mem;
   logic [DEPTH-1:0]       busy;
   logic                   wr_live;
   logic                   bs_live;
   logic                   wr_ok;
   logic                   bs_ok;

   // Holding reset also blinds the bypass so outputs read zero throughout.
   assign wr_live = wr_en & rst;
   assign bs_live = bs_en & rst;
   assign wr_ok   = wr_live && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR)));
   assign bs_ok   = bs_live && !((ZERO_REG != 0) && (bs_addr == ADDR_W'(ZERO_ADDR)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem  <= '0;
         busy <= '0;
      end else begin
         if (wr_ok) begin
            mem[int'(wr_addr)*WIDTH +: WIDTH] <= wr_data;
            busy[wr_addr]                     <= 1'b0;
         end
         // Placed after the clear so a new producer on the same address wins.
         if (bs_ok) begin
            busy[bs_addr] <= 1'b1;
         end
      end
   end

   assign busy_any = |busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      localparam int A_LO = slice_lo(i, ADDR_W);
      localparam int D_LO = slice_lo(i, WIDTH);

      regfile_read_port #(
         .WIDTH   (WIDTH),
         .DEPTH   (DEPTH),
         .ZERO_REG(ZERO_REG),
         .ADDR_W  (ADDR_W)
      ) u_port (
         .addr    (rd_addr[A_LO +: ADDR_W]),
         .mem     (mem),
         .busy_vec(busy),
         .wr_en   (wr_live),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .bs_en   (bs_live),
         .bs_addr (bs_addr),
         .data    (rd_data[D_LO +: WIDTH]),
         .flag    (rd_busy[i])
      );
   end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file with a per-register busy scoreboard for the MIPS datapath. It generalises the single 32-bit reset register into DEPTH words of WIDTH bits with NRD combinational read ports and one synchronous write port. It adds write-to-read bypass, an optional hardwired-zero register 0, and a busy bit per register that the decode stage uses to stall on pending writes. It sits between decode (reads, busy set) and writeback (write, busy clear).

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of registers. Power of two, at least 2.
- NRD, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- ADDR_W, $clog2(DEPTH): derived address width. Not overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Clears all registers and all busy bits.
- rd_addr  in  NRD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*WIDTH  packed read data; combinational.
- rd_busy  out  NRD  busy flag per read port; combinational.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- bs_en  in  1  busy-set strobe; marks a register as having a pending producer.
- bs_addr  in  ADDR_W  busy-set address.
- busy_any  out  1  OR of all busy bits, for drain and flush checks.

## Operation
- Storage: DEPTH × WIDTH flops plus a DEPTH-bit busy vector.
- Write: on the rising edge with wr_en=1, mem[wr_addr] ← wr_data and busy[wr_addr] ← 0. One exception: if bs_en=1 and bs_addr=wr_addr in the same cycle, busy stays set, because the new producer wins.
- Busy set: on the rising edge with bs_en=1, busy[bs_addr] ← 1.
- Read, port i:
  - If ZERO_REG=1 and rd_addr_i=0: rd_data_i=0 and rd_busy_i=0.
  - Else if wr_en=1 and wr_addr=rd_addr_i: bypass. rd_data_i=wr_data, and rd_busy_i=0 unless the same-cycle busy-set condition above holds for that address, in which case rd_busy_i=1.
  - Else: rd_data_i=mem[rd_addr_i] and rd_busy_i=busy[rd_addr_i].
- ZERO_REG=1: writes and busy-sets to address 0 are dropped, so mem[0] and busy[0] stay 0.
- All read ports are independent and may carry identical addresses.
- No arithmetic is performed. Data passes through unmodified at WIDTH bits.

## Timing
- Reset: while rst=0, asynchronously all mem=0 and busy=0. Writes, busy-sets and bypass are suppressed. Outputs are rd_data=0, rd_busy=0, busy_any=0.
- Reset deassertion: takes effect at the first rising edge after rst rises. A write presented on that edge is accepted.
- Reset mid-operation: asserting rst discards pending busy bits and data immediately, with no partial-write hazard.
- Write latency:
  - Via bypass, written data is visible on rd_data in the same cycle.
  - From storage, it is visible from the cycle after the edge.
- Busy latency: rd_busy rises the cycle after bs_en, and falls in the same cycle as the clearing write (via the bypass path).
- busy_any reflects registered busy bits only, not the bypass, so it lags by one cycle.
- No stall or handshake inside the block. The consumer stalls while rd_busy=1, and the producer asserts wr_en exactly once per bs_en.

## Structure
- Shared package regfile_pkg:
  - default WIDTH/DEPTH/NRD localparams;
  - ZERO_ADDR constant;
  - a function packing and unpacking the per-port address and data slices.
- Sub-module regfile_read_port: mux, zero-register masking and bypass compare for one port. It is instantiated NRD times in a generate loop.
- Top level holds the storage, busy vector, write/set logic and the busy_any reduction.

## Test plan
- Reset: hold rst=0 for 10 ns with wr_en=1, wr_addr=5, wr_data=32'hDEAD → rd_data=0 on both ports at address 5, and busy_any=0. After rst=1, the same write makes port 0 read 32'hDEAD at address 5.
- Bypass: write 32'h1234 to address 7 while port 1 reads address 7 → rd_data_1=32'h1234 in the same cycle. The next cycle, with wr_en=0, it still reads 32'h1234 from storage.
- Zero register: write 32'hFFFF_FFFF to address 0 with ZERO_REG=1 → port 0 at address 0 reads 0 in the same and later cycles. With ZERO_REG=0 it reads 32'hFFFF_FFFF.
- Scoreboard: bs_en at address 3 → next cycle rd_busy=1 for address 3 and busy_any=1. Then write 32'h42 to address 3 → rd_busy=0 and rd_data=32'h42 in that cycle, and busy_any=0 the cycle after.
- Simultaneous set and clear: bs_en and wr_en to address 9 on the same edge → busy[9]=1 and mem[9]=wr_data after the edge.
- Parameter sweep: WIDTH=8, DEPTH=4, NRD=3 → write then read all 4 addresses on all 3 ports matches the scoreboard model. Asserting rst mid-sequence clears every value to 0.
